seq_mul: RTL and testbench

Parametrised, multi-cycle shift-add multiplier for the stack CPU datapath, replacing the fixed 4-bit array multiplier. Multiplies two WIDTH-bit operands in WIDTH cycles with a start/busy/done handshake. Supports unsigned and two's-complement signed modes. Holds the full 2*WIDTH product until the next accepted start. Sits behind the ALU's MUL opcode; the control unit stalls on `busy`.

---
 rtl/seq_mul.sv | 91 +++++++++
 tb/tb_seq_mul.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul.sv
// Multi-cycle shift-add multiplier: WIDTH iterations per product, with unsigned
// and two's-complement modes. Signed operands are multiplied as magnitudes and
// the product is negated at the end when needed.
module seq_mul #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     operand1,
   input  logic [WIDTH-1:0]     operand2,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic               neg;
   logic [CNT_W-1:0]   count;

   logic [WIDTH-1:0]   mag1;
   logic [WIDTH-1:0]   mag2;
   logic [WIDTH:0]     upper_sum;
   logic [2*WIDTH-1:0] acc_next;

   // upper_sum keeps the carry out of the add; the shift brings it into the top bit
   always_comb begin
      mag1      = (signed_mode && operand1[WIDTH-1]) ? -operand1 : operand1;
      mag2      = (signed_mode && operand2[WIDTH-1]) ? -operand2 : operand2;
      upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
      acc_next  = (2*WIDTH)'({upper_sum, acc[WIDTH-1:0]} >> 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         neg     <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand  <= mag1;
                  mplier <= mag2;
                  neg    <= signed_mode && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                  acc    <= '0;
                  count  <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               // The final iteration's sum goes straight into product
               if (count == LAST) begin
                  product <= neg ? -acc_next : acc_next;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at WIDTH 4, 8 and 16. The driver queues expected
// products from an arithmetic reference; a negedge monitor checks each done.
module tb_seq_mul;

   typedef struct {
      logic [31:0] prod;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start [3];
   logic        sm    [3];
   logic [15:0] a     [3];
   logic [15:0] b     [3];
   logic        busy  [3];
   logic        done  [3];
   logic [31:0] prod  [3];
   logic [7:0]  p4;
   logic [15:0] p8;
   logic [31:0] p16;

   exp_t        exp_q [3][$];
   exp_t        mon_e;
   logic [31:0] held  [3];
   int          cycle = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycle++;

   seq_mul #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .signed_mode(sm[0]),
      .operand1(a[0][3:0]), .operand2(b[0][3:0]),
      .busy(busy[0]), .done(done[0]), .product(p4));

   seq_mul #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .signed_mode(sm[1]),
      .operand1(a[1][7:0]), .operand2(b[1][7:0]),
      .busy(busy[1]), .done(done[1]), .product(p8));

   seq_mul #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .signed_mode(sm[2]),
      .operand1(a[2]), .operand2(b[2]),
      .busy(busy[2]), .done(done[2]), .product(p16));

   assign prod[0] = {24'b0, p4};
   assign prod[1] = {16'b0, p8};
   assign prod[2] = p16;

   function automatic int wof(input int i);
      return 4 << i;
   endfunction

   // Reference: interpret operands as integers and multiply, keep 2*w bits
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                           input logic [15:0] y, input logic s);
      longint vx, vy, p, mask;
      vx = longint'(x);
      vy = longint'(y);
      if (s && x[w-1]) vx = vx - (longint'(1) << w);
      if (s && y[w-1]) vy = vy - (longint'(1) << w);
      p    = vx * vy;
      mask = (longint'(1) << (2 * w)) - 1;
      return 32'(p & mask);
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busy[i] === 1'b1 && done[i] === 1'b1) begin
            miscompares++;
            $display("[TB] FAIL busy_done_overlap w%0d: busy=1 done=1 required not both", wof(i));
         end
         if (rst_n !== 1'b1) begin
            held[i] = prod[i];
         end else if (done[i] === 1'b1) begin
            if (exp_q[i].size() == 0) begin
               miscompares++;
               $display("[TB] FAIL unexpected_done w%0d: done with no pending request, product=%h", wof(i), prod[i]);
            end else begin
               mon_e = exp_q[i].pop_front();
               vectors++;
               if (prod[i] !== mon_e.prod || cycle != mon_e.due) begin
                  miscompares++;
                  $display("[TB] FAIL product w%0d: got %h at cycle %0d, required %h at cycle %0d",
                           wof(i), prod[i], cycle, mon_e.prod, mon_e.due);
               end
            end
            held[i] = prod[i];
         end else begin
            if (prod[i] !== held[i]) begin
               miscompares++;
               $display("[TB] FAIL product_stable w%0d: got %h required held %h", wof(i), prod[i], held[i]);
               held[i] = prod[i];
            end
            if (exp_q[i].size() > 0 && cycle > exp_q[i][0].due) begin
               mon_e = exp_q[i].pop_front();
               miscompares++;
               $display("[TB] FAIL missing_done w%0d: no done by cycle %0d, required %h at cycle %0d",
                        wof(i), cycle, mon_e.prod, mon_e.due);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h required %h", name, act, expv);
      end
   endtask

   // Called at negedge+1; returns at negedge+1 of the cycle after the accepting edge
   task automatic applyStimulus(input int i, input logic [15:0] x, input logic [15:0] y,
                                input logic s, input logic hold, input logic [31:0] expv,
                                output int k);
      int guard = 0;
      start[i] = 1'b1;
      a[i]     = x;
      b[i]     = y;
      sm[i]    = s;
      while (busy[i] !== 1'b0 && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         miscompares++;
         $display("[TB] FAIL accept_timeout w%0d: busy stuck at %b, required 0", wof(i), busy[i]);
         start[i] = 1'b0;
         k = -1;
         return;
      end
      @(negedge clk); #1;
      k = cycle;
      exp_q[i].push_back('{prod: expv, due: k + wof(i)});
      if (!hold) start[i] = 1'b0;
      a[i]  = 16'($urandom);
      b[i]  = 16'($urandom);
      sm[i] = 1'($urandom);
   endtask

   task automatic waitIdle(input int i);
      int guard = 0;
      while ((busy[i] !== 1'b0 || exp_q[i].size() > 0) && guard < 100) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         miscompares++;
         $display("[TB] FAIL idle_timeout w%0d: busy=%b pending=%0d, required idle", wof(i), busy[i], exp_q[i].size());
      end
   endtask

   initial begin
      int k1, k2, idx, w, guard;
      logic [15:0] x, y, mask;
      logic s;

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; sm[i] = 1'b0; a[i] = '0; b[i] = '0;
      end
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_busy_w%0d", wof(i)), {31'b0, busy[i]}, 32'd0);
            checkOutput($sformatf("reset_done_w%0d", wof(i)), {31'b0, done[i]}, 32'd0);
            checkOutput($sformatf("reset_product_w%0d", wof(i)), prod[i], 32'd0);
         end
      end

      applyStimulus(0, 16'hF, 16'hF, 1'b0, 1'b0, 32'hE1, k1);
      applyStimulus(0, 16'h0, 16'h7, 1'b0, 1'b0, 32'h00, k1);
      applyStimulus(0, 16'h8, 16'h8, 1'b1, 1'b0, 32'h40, k1);
      applyStimulus(0, 16'hD, 16'h5, 1'b1, 1'b0, 32'hF1, k1);
      applyStimulus(0, 16'h7, 16'hF, 1'b1, 1'b0, 32'hF9, k1);
      applyStimulus(0, 16'h8, 16'h8, 1'b0, 1'b0, 32'h40, k1);
      applyStimulus(0, 16'hD, 16'h5, 1'b0, 1'b0, 32'h41, k1);
      waitIdle(0);

      applyStimulus(1, 16'd200, 16'd3, 1'b0, 1'b1, 32'h0258, k1);
      applyStimulus(1, 16'd17, 16'd11, 1'b0, 1'b0, 32'd187, k2);
      checkOutput("back_to_back_spacing", 32'(k2 - k1), 32'd9);
      applyStimulus(1, 16'd100, 16'd7, 1'b0, 1'b0, 32'd700, k1);
      @(negedge clk); #1;
      start[1] = 1'b1; a[1] = 16'd50; b[1] = 16'd50;
      @(negedge clk); #1;
      start[1] = 1'b0;
      applyStimulus(1, 16'h80, 16'h80, 1'b1, 1'b0, 32'h4000, k1);
      waitIdle(1);

      // Abort 255x255 in its third RUN cycle
      applyStimulus(1, 16'd255, 16'd255, 1'b0, 1'b0, 32'hFE01, k1);
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst_n = 1'b0;
      exp_q[1].delete();
      @(negedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         checkOutput("abort_done", {31'b0, done[1]}, 32'd0);
         checkOutput("abort_product", prod[1], 32'd0);
         @(negedge clk); #1;
      end
      applyStimulus(1, 16'd255, 16'd255, 1'b0, 1'b0, 32'hFE01, k1);
      waitIdle(1);

      for (int n = 0; n < 1000; n++) begin
         idx  = $urandom_range(0, 2);
         w    = wof(idx);
         mask = 16'((32'd1 << w) - 1);
         x    = 16'($urandom) & mask;
         y    = 16'($urandom) & mask;
         s    = 1'($urandom_range(0, 1));
         applyStimulus(idx, x, y, s, 1'b0, ref_mul(w, x, y, s), k1);
      end

      guard = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) > 0 && guard < 200) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 200) begin
         miscompares++;
         $display("[TB] FAIL drain_timeout: %0d results still pending, required 0",
                  exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
